// File: rtl/serial_add64_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_add64_pkg;

  localparam int DEF_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_add64_pkg

// File: rtl/serial_add64_add1.sv
// Team 1-bit full adder; the only arithmetic element of the serial datapath.
module add1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ cin;
  assign co  = (a & b) | (cin & (a ^ b));

endmodule : add1

// File: rtl/serial_add64.sv
// Bit-serial WIDTH-bit add/subtract: one bit pair per clock, LSB first, through
// a single full adder; result and flags are registered on entry to DONE.
module serial_add64
  import serial_add64_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;
  logic             fa_sum;
  logic             fa_co;

  add1 u_add1 (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // Result register with the current sum bit shifted in at the MSB.
  always_comb begin
    res_d = {fa_sum, res_q[WIDTH-1:1]};
  end

  // Control FSM, operand/result shift registers, counter and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          res_q   <= res_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // carry_q is the carry into the MSB during the final bit.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= fa_co;
            zf_q    <= (res_d == {WIDTH{1'b0}});
            sf_q    <= fa_sum;
            of_q    <= carry_q ^ fa_co;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign zf   = zf_q;
  assign sf   = sf_q;
  assign of   = of_q;

endmodule : serial_add64

// File: tb/tb_serial_add64.sv
// Self-checking bench for serial_add64: directed corner cases, randomized
// operations against an arithmetic reference model, back-to-back and reset.
module tb_serial_add64;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;
  logic        zf;
  logic        sf;
  logic        of;

  int pass_cnt;
  int total_cnt;
  int cyc;

  serial_add64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .zf    (zf),
    .sf    (sf),
    .of    (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain modular arithmetic plus signed range check for overflow.
  function automatic res_t ref_op(input logic [63:0] x, input logic [63:0] y, input logic s);
    res_t r;
    logic [64:0] u;
    logic signed [64:0] sx;
    logic signed [64:0] sy;
    logic signed [64:0] sr;
    sx = {x[63], x};
    sy = {y[63], y};
    if (s) begin
      r.s = x - y;
      r.c = (x >= y);
      sr  = sx - sy;
    end else begin
      u   = {1'b0, x} + {1'b0, y};
      r.s = u[63:0];
      r.c = u[64];
      sr  = sx + sy;
    end
    r.z = (r.s == 64'd0);
    r.n = r.s[63];
    r.v = (sr > 65'sd9223372036854775807) || (sr < -65'sd9223372036854775808);
    return r;
  endfunction

  // Launch one operation from IDLE, scramble inputs after capture, wait for done.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic ts,
                        output int lat, output logic busy_seen);
    int t0;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    busy_seen = busy;
    a = ~ta; b = ta ^ tb_v; sub = ~ts;
    while (!done && (cyc - t0) < 200) @(negedge clk);
    lat = cyc - t0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 64'd0; b = 64'd0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, sum, cout, zf, sf, of} !== 70'd0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c=%b z=%b s=%b o=%b, expected all 0",
               busy, done, sum, cout, zf, sf, of);
    end else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] da [4] = '{64'd5, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] db [4] = '{64'd3, 64'd7, 64'd1, 64'd1};
    logic        ds [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] es [4] = '{64'd8, 64'd0, 64'h8000_0000_0000_0000, 64'd0};
    logic [3:0]  ef [4] = '{4'b0000, 4'b1100, 4'b0011, 4'b1100};
    int lat;
    logic bs;
    for (int i = 0; i < 4; i++) begin
      run_op(da[i], db[i], ds[i], lat, bs);
      total_cnt++;
      if (lat !== 64) $display("FAIL dir%0d_latency: got %0d expected 64", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (bs !== 1'b1) $display("FAIL dir%0d_busy: got %b expected 1", i, bs);
      else pass_cnt++;
      total_cnt++;
      if (sum !== es[i]) $display("FAIL dir%0d_sum: got %h expected %h", i, sum, es[i]);
      else pass_cnt++;
      total_cnt++;
      if ({cout, zf, sf, of} !== ef[i])
        $display("FAIL dir%0d_flags: got czso=%b expected %b", i, {cout, zf, sf, of}, ef[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat;
    logic bs;
    logic [63:0] ra;
    logic [63:0] rb;
    logic rs;
    res_t e;
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      if (i % 4 == 1) rb = {1'b0, rb[62:0]} >> $urandom_range(0, 60);
      rs = 1'($urandom_range(0, 1));
      e = ref_op(ra, rb, rs);
      run_op(ra, rb, rs, lat, bs);
      total_cnt++;
      if (lat !== 64) $display("FAIL rnd%0d_latency: got %0d expected 64", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({sum, cout, zf, sf, of} !== {e.s, e.c, e.z, e.n, e.v})
        $display("FAIL rnd%0d_result: got %h czso=%b expected %h czso=%b",
                 i, sum, {cout, zf, sf, of}, e.s, {e.c, e.z, e.n, e.v});
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, b1, a2, b2;
    logic s1, s2;
    res_t e1, e2;
    int t0, t1, t2;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; s1 = 1'b0;
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; s2 = 1'b1;
    e1 = ref_op(a1, b1, s1);
    e2 = ref_op(a2, b2, s2);
    @(negedge clk);
    a = a1; b = b1; sub = s1; start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    repeat (10) @(negedge clk);
    a = a2; b = b2; sub = s2;
    while (!done && (cyc - t0) < 200) @(negedge clk);
    t1 = cyc;
    total_cnt++;
    if (t1 - t0 !== 64) $display("FAIL b2b_first_latency: got %0d expected 64", t1 - t0);
    else pass_cnt++;
    total_cnt++;
    if ({sum, cout, zf, sf, of} !== {e1.s, e1.c, e1.z, e1.n, e1.v})
      $display("FAIL b2b_first_result: got %h czso=%b expected %h czso=%b",
               sum, {cout, zf, sf, of}, e1.s, {e1.c, e1.z, e1.n, e1.v});
    else pass_cnt++;
    repeat (20) @(negedge clk);
    a = ~a2; b = ~b2; sub = 1'b0; start = 1'b0;
    while (!done && (cyc - t1) < 200) @(negedge clk);
    t2 = cyc;
    total_cnt++;
    if (t2 - t1 !== 66) $display("FAIL b2b_period: got %0d expected 66", t2 - t1);
    else pass_cnt++;
    total_cnt++;
    if ({sum, cout, zf, sf, of} !== {e2.s, e2.c, e2.z, e2.n, e2.v})
      $display("FAIL b2b_second_result: got %h czso=%b expected %h czso=%b",
               sum, {cout, zf, sf, of}, e2.s, {e2.c, e2.z, e2.n, e2.v});
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (sum !== e2.s || busy !== 1'b0)
      $display("FAIL b2b_hold: got sum=%h busy=%b expected sum=%h busy=0", sum, busy, e2.s);
    else pass_cnt++;
  endtask

  task automatic test_no_queue();
    int lat;
    logic bs;
    run_op(64'd100, 64'd1, 1'b1, lat, bs);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL no_queue_busy: got %b expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (sum !== 64'd99) $display("FAIL no_queue_sum: got %h expected %h", sum, 64'd99);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int done_seen;
    logic bs;
    @(negedge clk);
    a = 64'd1234; b = 64'd5678; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, sum, cout, zf, sf, of} !== 70'd0)
      $display("FAIL midrun_reset_outputs: got busy=%b done=%b sum=%h czso=%b expected all 0",
               busy, done, sum, {cout, zf, sf, of});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL midrun_no_done: got %0d pulses expected 0", done_seen);
    else pass_cnt++;
    run_op(64'd2, 64'd2, 1'b0, lat, bs);
    total_cnt++;
    if (lat !== 64 || sum !== 64'd4)
      $display("FAIL after_reset_op: got lat=%0d sum=%h expected lat=64 sum=%h", lat, sum, 64'd4);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    cyc = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_no_queue();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_serial_add64
